ecc_rd_checker: RTL and testbench

Single-port SECDED read-side checker that consumes the encoded read word produced by the latency-wrapped dual-port RAM (one instance per port). It aligns a read-request strobe to the RAM's read latency, decodes the `[ENCODED_WORD+1:1]` Hamming+overall-parity word, corrects single-bit errors, flags double-bit errors, and keeps saturating error counters plus a sticky first-failing address for software.

---
 rtl/ecc_pkg.sv | 58 +++++
 rtl/ecc_secded_dec.sv | 45 ++++
 rtl/ecc_rd_checker.sv | 132 +++++++++++++
 tb/tb_ecc_rd_checker.sv | 266 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ecc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ecc_pkg
// Brief    : SECDED Hamming+overall-parity helpers shared by the read checker.
// Revision : 1.0 - initial release
// ============================================================================
package ecc_pkg;

    // Functions work on a fixed maximum word size; callers pass the real width.
    localparam int ECC_MAX_W = 64;

    typedef logic [ECC_MAX_W:1]   ecc_word_t;
    typedef logic [ECC_MAX_W-1:0] ecc_data_t;
    typedef logic [7:0]           ecc_syn_t;

    function automatic int parity_bits(input int data_width);
        return $clog2(data_width) + 1;
    endfunction

    function automatic int encoded_word(input int data_width);
        return data_width + parity_bits(data_width);
    endfunction

    function automatic logic is_pow2(input int pos);
        return (pos > 0) && ((pos & (pos - 1)) == 0);
    endfunction

    function automatic ecc_syn_t syndrome(input ecc_word_t word, input int enc_w);
        ecc_syn_t  s;
        ecc_word_t sh;
        s = '0;
        for (int i = 1; i <= ECC_MAX_W; i++) begin
            sh = word >> (i - 1);
            if (i <= enc_w && sh[1]) begin
                s = s ^ ecc_syn_t'(i);
            end
        end
        return s;
    endfunction

    function automatic ecc_data_t extract_data(input ecc_word_t word, input int enc_w);
        ecc_data_t d;
        ecc_word_t sh;
        int        k;
        d = '0;
        k = 0;
        for (int i = 1; i <= ECC_MAX_W; i++) begin
            sh = word >> (i - 1);
            if (i <= enc_w && !is_pow2(i)) begin
                d = d | (ecc_data_t'(sh[1]) << k);
                k++;
            end
        end
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ecc_secded_dec.sv
`default_nettype none
// ============================================================================
// Module   : ecc_secded_dec
// Brief    : Combinational SECDED decode: correct single, flag double errors.
// Revision : 1.0 - initial release
// ============================================================================
module ecc_secded_dec
    import ecc_pkg::*;
#(
    parameter  int DATA_WIDTH   = 8,
    localparam int PARITY_BITS  = parity_bits(DATA_WIDTH),
    localparam int ENCODED_WORD = DATA_WIDTH + PARITY_BITS
) (
    input  logic [ENCODED_WORD+1:1] i_rdata,
    output logic [DATA_WIDTH-1:0]   o_data,
    output logic                    o_sbe,
    output logic                    o_dbe
);

    ecc_word_t w_word;
    ecc_word_t w_corr;
    ecc_data_t w_ext;
    ecc_syn_t  w_syn;
    logic      w_par;
    logic      w_in_range;
    logic      w_unused_ext_hi;

    assign w_word     = ecc_word_t'(i_rdata[ENCODED_WORD:1]);
    assign w_syn      = syndrome(w_word, ENCODED_WORD);
    assign w_par      = ^i_rdata;
    assign w_in_range = (w_syn != '0) && (w_syn <= ecc_syn_t'(ENCODED_WORD));

    // Only an odd-weight error with a syndrome inside the word is correctable.
    assign w_corr = (w_par && w_in_range) ? (w_word ^ (ecc_word_t'(1) << (w_syn - 8'd1)))
                                          : w_word;
    assign w_ext  = extract_data(w_corr, ENCODED_WORD);

    assign o_data = w_ext[DATA_WIDTH-1:0];
    assign o_sbe  = w_par && ((w_syn == '0) || w_in_range);
    assign o_dbe  = (w_syn != '0) && (!w_par || !w_in_range);

    assign w_unused_ext_hi = ^w_ext[ECC_MAX_W-1:DATA_WIDTH];

endmodule
`default_nettype wire

// File: rtl/ecc_rd_checker.sv
`default_nettype none
// ============================================================================
// Module   : ecc_rd_checker
// Brief    : Latency-aligned SECDED read checker with error counters/address.
// Revision : 1.0 - initial release
// ============================================================================
module ecc_rd_checker
    import ecc_pkg::*;
#(
    parameter  int DATA_WIDTH   = 8,
    parameter  int MEM_DEPTH    = 16,
    parameter  int ADDR_WIDTH   = $clog2(MEM_DEPTH),
    parameter  int RD_LATENCY   = 1,
    parameter  int CNT_WIDTH    = 8,
    localparam int PARITY_BITS  = parity_bits(DATA_WIDTH),
    localparam int ENCODED_WORD = DATA_WIDTH + PARITY_BITS
) (
    input  logic                    clka,
    input  logic                    rst,
    input  logic                    i_rd_req,
    input  logic [ADDR_WIDTH-1:0]   i_addr,
    input  logic [ENCODED_WORD+1:1] i_rdata,
    input  logic                    i_clr,
    output logic                    o_valid,
    output logic [DATA_WIDTH-1:0]   o_data,
    output logic                    o_sbe,
    output logic                    o_dbe,
    output logic [CNT_WIDTH-1:0]    o_sbe_cnt,
    output logic [CNT_WIDTH-1:0]    o_dbe_cnt,
    output logic [ADDR_WIDTH-1:0]   o_err_addr,
    output logic                    o_err_addr_vld
);

    logic [RD_LATENCY-1:0] r_vld_sr;
    logic [ADDR_WIDTH-1:0] r_addr_sr [RD_LATENCY];

    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_sbe;
    logic                  r_dbe;
    logic [CNT_WIDTH-1:0]  r_sbe_cnt;
    logic [CNT_WIDTH-1:0]  r_dbe_cnt;
    logic [ADDR_WIDTH-1:0] r_err_addr;
    logic                  r_err_addr_vld;

    logic                  w_aligned;
    logic [ADDR_WIDTH-1:0] w_aligned_addr;
    logic [DATA_WIDTH-1:0] w_dec_data;
    logic                  w_dec_sbe;
    logic                  w_dec_dbe;
    logic                  w_sbe_evt;
    logic                  w_dbe_evt;
    logic [CNT_WIDTH-1:0]  w_sbe_base;
    logic [CNT_WIDTH-1:0]  w_dbe_base;
    logic [CNT_WIDTH-1:0]  w_sbe_nxt;
    logic [CNT_WIDTH-1:0]  w_dbe_nxt;
    logic                  w_vld_base;
    logic                  w_capture;

    ecc_secded_dec #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_dec (
        .i_rdata (i_rdata),
        .o_data  (w_dec_data),
        .o_sbe   (w_dec_sbe),
        .o_dbe   (w_dec_dbe)
    );

    assign w_aligned      = r_vld_sr[RD_LATENCY-1];
    assign w_aligned_addr = r_addr_sr[RD_LATENCY-1];
    assign w_sbe_evt      = w_aligned && w_dec_sbe;
    assign w_dbe_evt      = w_aligned && w_dec_dbe;

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            r_vld_sr <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                r_addr_sr[i] <= '0;
            end
        end else begin
            r_vld_sr[0]  <= i_rd_req;
            r_addr_sr[0] <= i_addr;
            for (int i = 1; i < RD_LATENCY; i++) begin
                r_vld_sr[i]  <= r_vld_sr[i-1];
                r_addr_sr[i] <= r_addr_sr[i-1];
            end
        end
    end

    // Clear is applied first so a same-cycle error lands on the cleared state.
    always_comb begin
        w_sbe_base = i_clr ? '0 : r_sbe_cnt;
        w_dbe_base = i_clr ? '0 : r_dbe_cnt;
        w_vld_base = i_clr ? 1'b0 : r_err_addr_vld;
        w_sbe_nxt  = (w_sbe_evt && (w_sbe_base != '1)) ? w_sbe_base + 1'b1 : w_sbe_base;
        w_dbe_nxt  = (w_dbe_evt && (w_dbe_base != '1)) ? w_dbe_base + 1'b1 : w_dbe_base;
        w_capture  = (w_sbe_evt || w_dbe_evt) && !w_vld_base;
    end

    always_ff @(posedge clka or posedge rst) begin
        if (rst) begin
            r_valid        <= 1'b0;
            r_data         <= '0;
            r_sbe          <= 1'b0;
            r_dbe          <= 1'b0;
            r_sbe_cnt      <= '0;
            r_dbe_cnt      <= '0;
            r_err_addr     <= '0;
            r_err_addr_vld <= 1'b0;
        end else begin
            r_valid        <= w_aligned;
            r_data         <= w_aligned ? w_dec_data : '0;
            r_sbe          <= w_sbe_evt;
            r_dbe          <= w_dbe_evt;
            r_sbe_cnt      <= w_sbe_nxt;
            r_dbe_cnt      <= w_dbe_nxt;
            r_err_addr     <= w_capture ? w_aligned_addr : r_err_addr;
            r_err_addr_vld <= w_vld_base || w_capture;
        end
    end

    assign o_valid        = r_valid;
    assign o_data         = r_data;
    assign o_sbe          = r_sbe;
    assign o_dbe          = r_dbe;
    assign o_sbe_cnt      = r_sbe_cnt;
    assign o_dbe_cnt      = r_dbe_cnt;
    assign o_err_addr     = r_err_addr;
    assign o_err_addr_vld = r_err_addr_vld;

endmodule
`default_nettype wire

// File: tb/tb_ecc_rd_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_ecc_rd_checker
// Brief    : Scoreboard bench for ecc_rd_checker (latency 1 and latency 3).
// Revision : 1.0 - initial release
// ============================================================================
module tb_ecc_rd_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, rst3;
    logic        rd_req, clr, rd_req3, clr3;
    logic [3:0]  addr, addr3;
    logic [12:0] rdata, rdata3;

    logic        o_valid, o_sbe, o_dbe, o_err_addr_vld;
    logic [7:0]  o_data, o_sbe_cnt, o_dbe_cnt;
    logic [3:0]  o_err_addr;
    logic        o_valid3, o_sbe3, o_dbe3, o_err_addr_vld3;
    logic [7:0]  o_data3, o_sbe_cnt3, o_dbe_cnt3;
    logic [3:0]  o_err_addr3;

    int checks   = 0;
    int failures = 0;
    int v3_cnt   = 0;

    ecc_rd_checker #(.DATA_WIDTH(8), .MEM_DEPTH(16), .RD_LATENCY(1), .CNT_WIDTH(8)) dut (
        .clka(clk), .rst(rst), .i_rd_req(rd_req), .i_addr(addr), .i_rdata(rdata), .i_clr(clr),
        .o_valid(o_valid), .o_data(o_data), .o_sbe(o_sbe), .o_dbe(o_dbe),
        .o_sbe_cnt(o_sbe_cnt), .o_dbe_cnt(o_dbe_cnt),
        .o_err_addr(o_err_addr), .o_err_addr_vld(o_err_addr_vld)
    );

    ecc_rd_checker #(.DATA_WIDTH(8), .MEM_DEPTH(16), .RD_LATENCY(3), .CNT_WIDTH(8)) dut3 (
        .clka(clk), .rst(rst3), .i_rd_req(rd_req3), .i_addr(addr3), .i_rdata(rdata3), .i_clr(clr3),
        .o_valid(o_valid3), .o_data(o_data3), .o_sbe(o_sbe3), .o_dbe(o_dbe3),
        .o_sbe_cnt(o_sbe_cnt3), .o_dbe_cnt(o_dbe_cnt3),
        .o_err_addr(o_err_addr3), .o_err_addr_vld(o_err_addr_vld3)
    );

    typedef struct {
        logic [7:0] data;
        logic       sbe;
        logic       dbe;
        logic [7:0] sc;
        logic [7:0] dc;
        logic [3:0] ea;
        logic       ev;
    } exp_t;

    exp_t sb[$];

    logic [7:0] m_sc = '0;
    logic [7:0] m_dc = '0;
    logic [3:0] m_ea = '0;
    logic       m_ev = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Independent encoder: data in non-power-of-two positions, even parity.
    function automatic logic [12:0] enc(input logic [7:0] d);
        logic [12:0] w;
        logic        p;
        int          k;
        w = '0;
        k = 0;
        for (int i = 1; i <= 12; i++) begin
            if (!(i == 1 || i == 2 || i == 4 || i == 8)) begin
                w[i-1] = d[k];
                k++;
            end
        end
        for (int j = 0; j < 4; j++) begin
            p = 1'b0;
            for (int i = 1; i <= 12; i++) begin
                if (((i >> j) & 1) == 1) p = p ^ w[i-1];
            end
            w[(1 << j) - 1] = p;
        end
        w[12] = ^w[11:0];
        return w;
    endfunction

    function automatic logic [7:0] ext(input logic [12:0] w);
        logic [7:0] d;
        int         k;
        d = '0;
        k = 0;
        for (int i = 1; i <= 12; i++) begin
            if (!(i == 1 || i == 2 || i == 4 || i == 8)) begin
                d[k] = w[i-1];
                k++;
            end
        end
        return d;
    endfunction

    task automatic push_exp(input logic [7:0] d, input logic s, input logic db,
                            input logic [3:0] a, input logic c);
        exp_t e;
        if (c) begin
            m_sc = '0;
            m_dc = '0;
            m_ev = 1'b0;
        end
        if (s && m_sc != 8'hFF) m_sc = m_sc + 8'd1;
        if (db && m_dc != 8'hFF) m_dc = m_dc + 8'd1;
        if ((s || db) && !m_ev) begin
            m_ea = a;
            m_ev = 1'b1;
        end
        e.data = d; e.sbe = s; e.dbe = db;
        e.sc = m_sc; e.dc = m_dc; e.ea = m_ea; e.ev = m_ev;
        sb.push_back(e);
    endtask

    // One read on the latency-1 DUT: request, then data (and optional clear).
    task automatic rd1(input logic [3:0] a, input logic [12:0] w, input logic [7:0] d,
                       input logic s, input logic db, input logic c);
        rd_req = 1'b1;
        addr   = a;
        push_exp(d, s, db, a, c);
        @(posedge clk); #1;
        rd_req = 1'b0;
        rdata  = w;
        clr    = c;
        @(posedge clk); #1;
        clr    = 1'b0;
    endtask

    always @(negedge clk) begin
        if (o_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_valid", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("data", o_data, e.data);
                chk("sbe", o_sbe, e.sbe);
                chk("dbe", o_dbe, e.dbe);
                chk("sbe_cnt", o_sbe_cnt, e.sc);
                chk("dbe_cnt", o_dbe_cnt, e.dc);
                chk("err_addr_vld", o_err_addr_vld, e.ev);
                if (e.ev) chk("err_addr", o_err_addr, e.ea);
            end
        end else if (!rst) begin
            chk("idle_zero", {o_data, o_sbe, o_dbe}, 32'd0);
        end
        if (o_valid3) v3_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  d;
        logic [12:0] w;
        int          pa, pb, v3_before;

        rst = 1'b1; rst3 = 1'b1;
        rd_req = 1'b0; clr = 1'b0; addr = '0; rdata = '0;
        rd_req3 = 1'b0; clr3 = 1'b0; addr3 = '0; rdata3 = enc(8'h5A);
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outs", {o_valid, o_data, o_sbe, o_dbe, o_sbe_cnt, o_dbe_cnt, o_err_addr, o_err_addr_vld}, 32'd0);
        chk("reset_outs3", {o_valid3, o_data3, o_sbe3, o_dbe3, o_sbe_cnt3, o_dbe_cnt3, o_err_addr3, o_err_addr_vld3}, 32'd0);
        rst = 1'b0; rst3 = 1'b0;
        @(posedge clk); #1;

        // Clean word with explicit latency check
        rd_req = 1'b1; addr = 4'd3;
        push_exp(8'h01, 1'b0, 1'b0, 4'd3, 1'b0);
        @(posedge clk); #1;
        chk("lat1_not_yet", o_valid, 1'b0);
        rd_req = 1'b0; rdata = 13'h1007;
        @(posedge clk); #1;
        chk("lat1_valid", o_valid, 1'b1);

        rd1(4'd7, 13'h0010, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("first_err_addr", {o_err_addr_vld, o_err_addr}, {1'b1, 4'd7});
        rd1(4'd9, 13'h0014, 8'h03, 1'b0, 1'b1, 1'b0);
        chk("err_addr_kept", o_err_addr, 4'd7);
        rd1(4'd2, 13'h1000, 8'h00, 1'b1, 1'b0, 1'b0);
        rd1(4'd4, 13'h0803, 8'h80, 1'b0, 1'b1, 1'b0);

        for (int n = 0; n < 8; n++) begin
            d  = 8'($urandom);
            pa = $urandom_range(1, 13);
            pb = $urandom_range(1, 12);
            if (pb >= pa) pb = pb + 1;
            rd1(4'(n), enc(d), d, 1'b0, 1'b0, 1'b0);
            rd1(4'(n + 1), enc(d) ^ (13'd1 << (pa - 1)), d, 1'b1, 1'b0, 1'b0);
            w = enc(d) ^ (13'd1 << (pa - 1)) ^ (13'd1 << (pb - 1));
            rd1(4'(n + 2), w, ext(w), 1'b0, 1'b1, 1'b0);
        end

        // Back-to-back SBE burst into saturation
        rdata = 13'h0010;
        for (int n = 0; n < 300; n++) begin
            rd_req = 1'b1;
            addr   = 4'(n);
            push_exp(8'h00, 1'b1, 1'b0, 4'(n), 1'b0);
            @(posedge clk); #1;
        end
        rd_req = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("sbe_cnt_saturated", o_sbe_cnt, 8'hFF);

        rd1(4'd5, 13'h0010, 8'h00, 1'b1, 1'b0, 1'b1);
        chk("clr_sbe_cnt", o_sbe_cnt, 8'd1);
        chk("clr_dbe_cnt", o_dbe_cnt, 8'd0);
        chk("clr_err_addr", {o_err_addr_vld, o_err_addr}, {1'b1, 4'd5});

        // Latency-3 instance: timing, then reset with reads in flight
        rd_req3 = 1'b1; addr3 = 4'd1;
        @(posedge clk); #1;
        rd_req3 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("lat3_not_yet", o_valid3, 1'b0);
        @(posedge clk); #1;
        chk("lat3_valid", {o_valid3, o_data3, o_sbe3, o_dbe3}, {1'b1, 8'h5A, 1'b0, 1'b0});
        @(posedge clk); #1;
        v3_before = v3_cnt;
        rd_req3 = 1'b1; addr3 = 4'd2;
        @(posedge clk); #1;
        addr3 = 4'd3;
        @(posedge clk); #1;
        rd_req3 = 1'b0;
        rst3 = 1'b1;
        #1;
        chk("rst3_outs", {o_valid3, o_data3, o_sbe3, o_dbe3, o_sbe_cnt3, o_dbe_cnt3, o_err_addr3, o_err_addr_vld3}, 32'd0);
        @(posedge clk); #1;
        chk("rst3_hold", {o_valid3, o_data3, o_sbe3, o_dbe3}, 32'd0);
        rst3 = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("rst3_dropped", v3_cnt, v3_before);
        rd_req3 = 1'b1; addr3 = 4'd4;
        @(posedge clk); #1;
        rd_req3 = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("rst3_third", v3_cnt, v3_before + 1);

        for (int n = 0; n < 20 && sb.size() != 0; n++) @(posedge clk);
        #1;
        chk("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
